unitate_executie: RTL
=====================

UNITATE_EXECUTIE -- requirements
Module: unitate_executie

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width.
REQ-002 SHALL have parameter REG_ADDR_W, default 4, register-address width (16 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  operation request, accepted only while ready=1.
REQ-006 SHALL have port opcode  input  4  operation select.
REQ-007 SHALL have ports op_a, op_b  input  DATA_W  operands, driven by the register file's read_data1/read_data2.
REQ-008 SHALL have port dest_reg  input  REG_ADDR_W  destination register.
REQ-009 SHALL have port ready  output  1  high only in IDLE.
REQ-010 SHALL have ports write_enable (1), write_reg (REG_ADDR_W), write_data (DATA_W)  outputs  registered writeback to the register file.
REQ-011 SHALL have ports zero, carry, illegal  output  1  registered status.

Function
REQ-012 SHALL sample opcode, op_a, op_b and dest_reg on the edge where start=1 and ready=1 (the accept edge). start while ready=0 SHALL be ignored.
REQ-013 SHALL implement FSM states IDLE, ITER and WB: IDLE->WB for single-cycle ops, IDLE->ITER for MUL/DIV, ITER->WB after 8 iterations, and WB->IDLE unconditionally.
REQ-014 SHALL assign opcodes as follows: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by 1, 7 SHR a by 1 (logical), 8 MOV b, 9 CMP (a-b, flags only), 10 MUL, 11 DIV (a/b quotient), 12-15 illegal.
REQ-015 SHALL, for single-cycle ops, pulse write_enable for exactly one cycle, the cycle after the accept edge, so that ready returns one cycle after that.
REQ-016 SHALL, for MUL/DIV, run one shift-add or restore-subtract step per cycle for 8 cycles and pulse write_enable in the 9th cycle after the accept edge.
REQ-017 SHALL, during a write_enable pulse, drive write_reg to the sampled dest_reg and write_data to the result's low DATA_W bits.
REQ-018 SHALL hold write_enable low outside a write_enable pulse, and SHALL hold write_data/write_reg stable until the next writeback.
REQ-019 SHALL update carry at WB as follows: ADD carry-out; SUB/CMP borrow (a<b); SHL old bit7; SHR old bit0; MUL 1 if the 16-bit product exceeds 255; DIV 1 on divide-by-zero; all other ops 0.
REQ-020 SHALL set zero at WB when the result is 0, where the CMP result is a-b mod 256.
REQ-021 SHALL, for CMP and illegal opcodes, keep write_enable low; illegal opcodes SHALL pulse illegal for one cycle in WB and leave zero/carry unchanged.
REQ-022 SHALL, for DIV with b=0, produce write_data=8'hFF and carry=1 with normal 9-cycle latency.
REQ-023 SHALL let wrap-around occur silently: ADD/SUB results are mod 256.

Reset
REQ-024 SHALL, while rst=1, force state IDLE, ready=1, write_enable=0, write_reg=0, write_data=0, zero=0, carry=0, illegal=0 and the iteration counter to 0.
REQ-025 SHALL, when reset asserts in ITER or WB, abort the operation with no writeback, including one whose WB would fall in that cycle.
REQ-026 SHALL give rst priority over start when both are high on the same edge.

Configuration
REQ-027 SHALL use macro UNITATE_EXECUTIE_MULDIV_EN; when defined, opcodes 10/11 SHALL behave per REQ-016/019/022.
REQ-028 SHALL, without UNITATE_EXECUTIE_MULDIV_EN, treat opcodes 10/11 as illegal (REQ-021), make ITER unreachable and synthesize no multiply/divide datapath.

Structure
REQ-029 SHALL define opcode constants, FSM state encoding, the iteration count (8) and the width defaults in shared package pachet_executie.
REQ-030 SHALL place the iterative multiply/divide datapath in sub-module unitate_muldiv (inputs start/a/b/is_div, outputs result/carry/done), instantiated only under UNITATE_EXECUTIE_MULDIV_EN.

Verification
REQ-031 SHALL verify: ADD a=200 b=100 dest=3 -> next cycle write_enable=1, write_reg=3, write_data=44, carry=1, zero=0.
REQ-032 SHALL verify: CMP a=5 b=5 -> write_enable stays 0, zero=1, carry=0; then SUB a=3 b=4 -> write_data=255, carry=1.
REQ-033 SHALL verify, with MULDIV_EN defined: MUL 16*8 -> write_data=128, carry=0, at cycle 9; MUL 32*16 -> write_data=0, carry=1, zero=1; DIV 255/0 -> write_data=255, carry=1.
REQ-034 SHALL verify: start asserted during ITER with a different opcode -> ignored, and the original MUL result written once.
REQ-035 SHALL verify: rst pulsed on the 4th ITER cycle -> no write_enable, ready=1 next cycle, and all outputs at reset values.
REQ-036 SHALL verify: opcode 14, and opcode 10 without MULDIV_EN -> illegal one-cycle pulse, no write, and zero/carry unchanged.

Source files
------------

// File: rtl/unitate_executie_pkg.sv
// Shared definitions for the execution unit: width defaults, the number of
// multiply/divide iterations, opcode values and the control FSM encoding.
// No ports; imported by unitate_executie and unitate_muldiv.
package pachet_executie;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned REG_ADDR_W_DEF = 4;
    localparam int unsigned ITERATII       = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MOV = 4'd8,
        OP_CMP = 4'd9,
        OP_MUL = 4'd10,
        OP_DIV = 4'd11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_WB   = 2'd2
    } stare_e;

endpackage

// File: rtl/unitate_executie_muldiv.sv
// Iterative 8-step multiplier (shift-add, multiplier LSB first) and
// restoring divider (quotient MSB first). Only built when the macro
// UNITATE_EXECUTIE_MULDIV_EN is defined.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and begin iterating
//   a, b            operands (multiplicand/multiplier, dividend/divisor)
//   is_div          1 = divide, 0 = multiply
//   result          low W bits of product, or quotient (all ones on b=0)
//   carry           product overflowed W bits, or divide by zero
//   done            high during the final step; result/carry valid then
`ifdef UNITATE_EXECUTIE_MULDIV_EN
module unitate_muldiv
    import pachet_executie::*;
#(
    parameter int unsigned W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_div,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         done
);

    localparam int unsigned CW = $clog2(ITERATII);

    logic         busy;
    logic         div_q;
    logic [CW-1:0] cnt;
    // hi/lo: product halves for multiply, remainder/quotient for divide
    logic [W-1:0] hi, lo, a_q, b_q;
    logic [W-1:0] hi_n, lo_n;
    logic [W:0]   sum, shifted, trial;
    logic         b_zero;

    assign b_zero = (b_q == '0);

    always_comb begin
        sum     = '0;
        shifted = '0;
        trial   = '0;
        hi_n    = hi;
        lo_n    = lo;
        if (div_q) begin
            shifted = {hi, lo[W-1]};
            trial   = shifted - {1'b0, b_q};
            if (!trial[W]) begin
                hi_n = trial[W-1:0];
                lo_n = {lo[W-2:0], 1'b1};
            end else begin
                hi_n = shifted[W-1:0];
                lo_n = {lo[W-2:0], 1'b0};
            end
        end else begin
            sum  = {1'b0, hi} + {1'b0, (lo[0] ? a_q : '0)};
            hi_n = sum[W:1];
            lo_n = {sum[0], lo[W-1:1]};
        end
    end

    // Outputs present the post-step value so the caller can write back on
    // the same edge as the last step.
    assign done   = busy && (cnt == CW'(ITERATII - 1));
    assign result = (div_q && b_zero) ? '1 : lo_n;
    assign carry  = div_q ? b_zero : (hi_n != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div_q <= is_div;
            cnt   <= '0;
            hi    <= '0;
            lo    <= is_div ? a : b;
            a_q   <= a;
            b_q   <= b;
        end else if (busy) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/unitate_executie.sv
// Execution unit: single-cycle ALU ops plus optional iterative MUL/DIV,
// with registered writeback to a register file and registered status flags.
// Optional feature macro: UNITATE_EXECUTIE_MULDIV_EN (enables opcodes 10/11;
// otherwise they are illegal and no multiply/divide logic is built).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, opcode, op_a, op_b      operation request and operands
//   dest_reg                       destination register
//   ready                          high only in IDLE
//   write_enable/write_reg/write_data  one-cycle writeback pulse
//   zero, carry, illegal           registered status
module unitate_executie
    import pachet_executie::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            opcode,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  ready,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic                  zero,
    output logic                  carry,
    output logic                  illegal
);

    stare_e state, next_state;
    logic   accept;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              op_illegal, op_iter, op_cmp;
    logic [DATA_W:0]   sum, diff;

    assign ready  = (state == ST_IDLE);
    assign accept = start && ready;
    assign sum    = {1'b0, op_a} + {1'b0, op_b};
    assign diff   = {1'b0, op_a} - {1'b0, op_b};
    assign op_cmp = (opcode == OP_CMP);

    always_comb begin
        alu_res    = '0;
        alu_carry  = 1'b0;
        op_illegal = 1'b0;
        op_iter    = 1'b0;
        case (opcode)
            OP_ADD: begin alu_res = sum[DATA_W-1:0]; alu_carry = sum[DATA_W]; end
            OP_SUB,
            OP_CMP: begin alu_res = diff[DATA_W-1:0]; alu_carry = diff[DATA_W]; end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_NOT: alu_res = ~op_a;
            OP_SHL: begin alu_res = {op_a[DATA_W-2:0], 1'b0}; alu_carry = op_a[DATA_W-1]; end
            OP_SHR: begin alu_res = {1'b0, op_a[DATA_W-1:1]}; alu_carry = op_a[0]; end
            OP_MOV: alu_res = op_b;
`ifdef UNITATE_EXECUTIE_MULDIV_EN
            OP_MUL,
            OP_DIV: op_iter = 1'b1;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

`ifdef UNITATE_EXECUTIE_MULDIV_EN
    logic [DATA_W-1:0]     md_result;
    logic                  md_carry, md_done;
    logic [REG_ADDR_W-1:0] dest_q;

    unitate_muldiv #(
        .W(DATA_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && op_iter),
        .a      (op_a),
        .b      (op_b),
        .is_div (opcode == OP_DIV),
        .result (md_result),
        .carry  (md_carry),
        .done   (md_done)
    );

    always_ff @(posedge clk) begin
        if (rst)         dest_q <= '0;
        else if (accept) dest_q <= dest_reg;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = op_iter ? ST_ITER : ST_WB;
`ifdef UNITATE_EXECUTIE_MULDIV_EN
            ST_ITER: if (md_done) next_state = ST_WB;
`else
            ST_ITER: next_state = ST_IDLE;
`endif
            ST_WB:   next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Writeback and flags are registered on the edge entering WB, so they are
    // visible exactly during the WB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            zero         <= 1'b0;
            carry        <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            illegal      <= 1'b0;
            if (accept && !op_iter) begin
                if (op_illegal) begin
                    illegal <= 1'b1;
                end else begin
                    zero  <= (alu_res == '0);
                    carry <= alu_carry;
                    if (!op_cmp) begin
                        write_enable <= 1'b1;
                        write_reg    <= dest_reg;
                        write_data   <= alu_res;
                    end
                end
            end
`ifdef UNITATE_EXECUTIE_MULDIV_EN
            if (state == ST_ITER && md_done) begin
                write_enable <= 1'b1;
                write_reg    <= dest_q;
                write_data   <= md_result;
                zero         <= (md_result == '0);
                carry        <= md_carry;
            end
`endif
        end
    end

endmodule
